// File: rtl/vga_timing_generator.sv
// Raster timing for 640x480@60 Hz: pixel-tick divider, h/v counters,
// registered syncs, visible-window flag and a free-running frame counter.
module vga_timing_generator #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP_END  = 144,
    parameter int unsigned H_VIS_END = 784,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP_END  = 35,
    parameter int unsigned V_VIS_END = 515,
    parameter int unsigned V_TOTAL   = 525
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pixel_tick,
    output logic       frame_start,
    output logic [3:0] frame_count
);

    localparam int unsigned CW = 10;
    localparam int unsigned DW = $clog2(DIV);

    logic [DW-1:0] divider;
    logic [DW-1:0] divider_nxt;
    logic          tick_nxt;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          frame_wrap;

    // Next divider/counter values; syncs and bright are derived from these so
    // they register on the same edge as the counters.
    always_comb begin
        divider_nxt = divider + DW'(1);
        tick_nxt    = 1'b0;
        h_nxt       = hCount;
        v_nxt       = vCount;
        frame_wrap  = 1'b0;

        if (divider == DW'(DIV - 1)) begin
            divider_nxt = '0;
        end
        tick_nxt = (divider_nxt == DW'(DIV - 1));

        if (pixel_tick) begin
            if (hCount == CW'(H_TOTAL - 1)) begin
                h_nxt = '0;
                if (vCount == CW'(V_TOTAL - 1)) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vCount + CW'(1);
                end
            end else begin
                h_nxt = hCount + CW'(1);
            end
        end
    end

    // State and registered outputs; reset parks the raster at (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divider     <= '0;
            pixel_tick  <= 1'b0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            divider     <= divider_nxt;
            pixel_tick  <= tick_nxt;
            hCount      <= h_nxt;
            vCount      <= v_nxt;
            hSync       <= (h_nxt >= CW'(H_SYNC));
            vSync       <= (v_nxt >= CW'(V_SYNC));
            bright      <= (h_nxt >= CW'(H_BP_END)) && (h_nxt < CW'(H_VIS_END)) &&
                           (v_nxt >= CW'(V_BP_END)) && (v_nxt < CW'(V_VIS_END));
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a full-size instance for tick/line/reset
// behaviour and a shrunken-raster instance for frame-level behaviour.
module tb_vga_timing_generator;

    logic clk;
    logic ra;
    logic rb;

    logic [9:0] ha, va, hb, vb;
    logic       hsa, vsa, bra, pta, fsa;
    logic       hsb, vsb, brb, ptb, fsb;
    logic [3:0] fca, fcb;

    int checks = 0;
    int errors = 0;
    int hs_low_a = 0;

    // Small raster: 16 px x 10 lines, frame = 16*10*4 = 640 clks.
    localparam int FRAME_B = 640;

    vga_timing_generator dut_a (
        .clk(clk), .reset(ra), .hCount(ha), .vCount(va), .hSync(hsa), .vSync(vsa),
        .bright(bra), .pixel_tick(pta), .frame_start(fsa), .frame_count(fca)
    );

    vga_timing_generator #(
        .DIV(4), .H_SYNC(4), .H_BP_END(6), .H_VIS_END(14), .H_TOTAL(16),
        .V_SYNC(2), .V_BP_END(3), .V_VIS_END(8), .V_TOTAL(10)
    ) dut_b (
        .clk(clk), .reset(rb), .hCount(hb), .vCount(vb), .hSync(hsb), .vSync(vsb),
        .bright(brb), .pixel_tick(ptb), .frame_start(fsb), .frame_count(fcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {h, v, hSync, vSync, bright, pixel_tick, frame_start, frame_count}
    // n clock edges after reset release (DIV = 4).
    function automatic logic [28:0] exp_vec(input int n, input int hsw, input int hbp,
                                            input int hvis, input int ht, input int vsw,
                                            input int vbp, input int vvis, input int vt);
        int p, h, v, fr;
        logic [9:0] hh, vv;
        logic [3:0] fc;
        logic fs, tk, hs, vs, br;
        p  = n / 4;
        h  = p % ht;
        v  = (p / ht) % vt;
        fr = ht * vt * 4;
        hh = 10'(h);
        vv = 10'(v);
        fc = 4'((n / fr) % 16);
        fs = (n > 0) && (n % fr == 0);
        tk = (n % 4 == 3);
        hs = (h >= hsw);
        vs = (v >= vsw);
        br = (h >= hbp) && (h < hvis) && (v >= vbp) && (v < vvis);
        return {hh, vv, hs, vs, br, tk, fs, fc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-clock invariants on both instances.
    int  gap_a = 0, gap_b = 0;
    bit  seen_a = 0, seen_b = 0, dead_a = 0, dead_b = 0;
    always @(negedge clk) begin
        if (!ra) begin
            gap_a = 0; seen_a = 0;
        end else if (!dead_a) begin
            gap_a++;
            checks++;
            if (ha >= 10'd800 || va >= 10'd525 || (bra && !(hsa && vsa)) ||
                (pta && seen_a && gap_a != 4)) begin
                errors++; dead_a = 1;
                $display("FAIL invariant_a: h=%0d v=%0d br=%0b hs=%0b vs=%0b tick_gap=%0d, required h<800 v<525 br->hs&vs gap=4",
                         ha, va, bra, hsa, vsa, gap_a);
            end
            if (pta) begin seen_a = 1; gap_a = 0; end
        end
        if (!rb) begin
            gap_b = 0; seen_b = 0;
        end else if (!dead_b) begin
            gap_b++;
            checks++;
            if (hb >= 10'd16 || vb >= 10'd10 || (brb && !(hsb && vsb)) ||
                (ptb && seen_b && gap_b != 4)) begin
                errors++; dead_b = 1;
                $display("FAIL invariant_b: h=%0d v=%0d br=%0b hs=%0b vs=%0b tick_gap=%0d, required h<16 v<10 br->hs&vs gap=4",
                         hb, vb, brb, hsb, vsb, gap_b);
            end
            if (ptb) begin seen_b = 1; gap_b = 0; end
        end
    end

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({ha, va, hsa, vsa, bra, pta, fsa, fca} !== 29'd0) begin
            errors++;
            $display("FAIL reset_a: got %h, required 0", {ha, va, hsa, vsa, bra, pta, fsa, fca});
        end
        checks++;
        if ({hb, vb, hsb, vsb, brb, ptb, fsb, fcb} !== 29'd0) begin
            errors++;
            $display("FAIL reset_b: got %h, required 0", {hb, vb, hsb, vsb, brb, ptb, fsb, fcb});
        end
    endtask

    // Release, then edges 1..4: tick only in the 4th cycle, hCount 0->1 at edge 4.
    task automatic test_pixel_tick();
        logic       tick_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [9:0] h_tab    [5] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd1};
        ra = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            if (hsa == 1'b0) hs_low_a++;
            checks++;
            if ({pta, ha, va, hsa, vsa, bra} !== {tick_tab[i], h_tab[i], 10'd0, 3'b000}) begin
                errors++;
                $display("FAIL pixel_tick[%0d]: tick=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b, required tick=%0b h=%0d v=0 syncs/bright=0",
                         i, pta, ha, va, hsa, vsa, bra, tick_tab[i], h_tab[i]);
            end
        end
    endtask

    // Rest of line 0 up to the wrap into line 1.
    task automatic test_line();
        bit bad = 0;
        bit rose = 0;
        logic [28:0] e;
        for (int n = 5; n <= 3200; n++) begin
            step();
            if (n < 3200 && hsa == 1'b0) hs_low_a++;
            if (!rose && hsa) begin
                rose = 1;
                checks++;
                if (ha !== 10'd96) begin
                    errors++;
                    $display("FAIL hsync_rise: hCount=%0d, required 96", ha);
                end
            end
            e = exp_vec(n, 96, 144, 784, 800, 2, 35, 515, 525);
            if (!bad) begin
                checks++;
                if ({ha, va, hsa, vsa, bra, pta, fsa, fca} !== e) begin
                    errors++; bad = 1;
                    $display("FAIL line_scan n=%0d: got %h, required %h", n,
                             {ha, va, hsa, vsa, bra, pta, fsa, fca}, e);
                end
            end
        end
        checks++;
        if (ha !== 10'd0 || va !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap: h=%0d v=%0d, required h=0 v=1", ha, va);
        end
        checks++;
        if (hs_low_a != 384) begin
            errors++;
            $display("FAIL hsync_low_time: %0d clks, required 384", hs_low_a);
        end
    endtask

    // Async reset at (400,1): outputs clear before the next edge.
    task automatic test_async_reset();
        for (int n = 3201; n <= 4800; n++) step();
        checks++;
        if (ha !== 10'd400 || va !== 10'd1 || hsa !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pos: h=%0d v=%0d hs=%0b, required h=400 v=1 hs=1", ha, va, hsa);
        end
        ra = 1'b0;
        #2;
        checks++;
        if ({ha, va, hsa, vsa, bra, pta, fsa, fca} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset_a: got %h, required 0", {ha, va, hsa, vsa, bra, pta, fsa, fca});
        end
    endtask

    // First frame of the small raster: visible window and bright count.
    task automatic test_bright();
        bit bad = 0, rose = 0, fell = 0;
        int br_cnt = 0;
        logic [28:0] e;
        rb = 1'b1;
        for (int n = 0; n < FRAME_B; n++) begin
            if (n > 0) step();
            if (brb) br_cnt++;
            if (!rose && brb) begin
                rose = 1;
                checks++;
                if (hb !== 10'd6 || vb !== 10'd3) begin
                    errors++;
                    $display("FAIL bright_rise: h=%0d v=%0d, required h=6 v=3", hb, vb);
                end
            end
            if (rose && !fell && !brb) begin
                fell = 1;
                checks++;
                if (hb !== 10'd14 || vb !== 10'd3) begin
                    errors++;
                    $display("FAIL bright_fall: h=%0d v=%0d, required h=14 v=3", hb, vb);
                end
            end
            e = exp_vec(n, 4, 6, 14, 16, 2, 3, 8, 10);
            if (!bad) begin
                checks++;
                if ({hb, vb, hsb, vsb, brb, ptb, fsb, fcb} !== e) begin
                    errors++; bad = 1;
                    $display("FAIL bright_scan n=%0d: got %h, required %h", n,
                             {hb, vb, hsb, vsb, brb, ptb, fsb, fcb}, e);
                end
            end
        end
        checks++;
        if (br_cnt != 160) begin
            errors++;
            $display("FAIL bright_count: %0d clks, required 160", br_cnt);
        end
    endtask

    // Sixteen frame wraps: one-clk frame_start each, frame_count back to 0.
    task automatic test_frame_wrap();
        bit bad = 0;
        int fs_cnt = 0;
        logic [28:0] e;
        for (int n = FRAME_B; n <= 16 * FRAME_B; n++) begin
            step();
            if (fsb) fs_cnt++;
            if (n == FRAME_B) begin
                checks++;
                if ({fsb, hb, vb, fcb} !== {1'b1, 10'd0, 10'd0, 4'd1}) begin
                    errors++;
                    $display("FAIL first_wrap: fs=%0b h=%0d v=%0d fc=%0d, required fs=1 h=0 v=0 fc=1",
                             fsb, hb, vb, fcb);
                end
            end
            e = exp_vec(n, 4, 6, 14, 16, 2, 3, 8, 10);
            if (!bad) begin
                checks++;
                if ({hb, vb, hsb, vsb, brb, ptb, fsb, fcb} !== e) begin
                    errors++; bad = 1;
                    $display("FAIL frame_scan n=%0d: got %h, required %h", n,
                             {hb, vb, hsb, vsb, brb, ptb, fsb, fcb}, e);
                end
            end
        end
        checks++;
        if (fs_cnt != 16 || fcb !== 4'd0 || fsb !== 1'b1) begin
            errors++;
            $display("FAIL frame_count_wrap: pulses=%0d fc=%0d fs=%0b, required 16, 0, 1", fs_cnt, fcb, fsb);
        end
    endtask

    // Reset mid-frame at (8,5), then a clean restart with no partial-frame pulse.
    task automatic test_mid_reset();
        bit bad = 0;
        int vs_low = 0;
        logic [28:0] e;
        for (int n = 16 * FRAME_B + 1; n <= 16 * FRAME_B + 352; n++) step();
        checks++;
        if (hb !== 10'd8 || vb !== 10'd5 || brb !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pos_b: h=%0d v=%0d br=%0b, required h=8 v=5 br=1", hb, vb, brb);
        end
        rb = 1'b0;
        #2;
        checks++;
        if ({hb, vb, hsb, vsb, brb, ptb, fsb, fcb} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset_b: got %h, required 0", {hb, vb, hsb, vsb, brb, ptb, fsb, fcb});
        end
        repeat (3) step();
        checks++;
        if ({hb, vb, hsb, vsb, brb, ptb, fsb, fcb} !== 29'd0) begin
            errors++;
            $display("FAIL reset_hold_b: got %h, required 0", {hb, vb, hsb, vsb, brb, ptb, fsb, fcb});
        end
        rb = 1'b1;
        for (int n = 0; n <= FRAME_B; n++) begin
            if (n > 0) step();
            if (n < FRAME_B && !vsb) vs_low++;
            e = exp_vec(n, 4, 6, 14, 16, 2, 3, 8, 10);
            if (!bad) begin
                checks++;
                if ({hb, vb, hsb, vsb, brb, ptb, fsb, fcb} !== e) begin
                    errors++; bad = 1;
                    $display("FAIL restart_scan n=%0d: got %h, required %h", n,
                             {hb, vb, hsb, vsb, brb, ptb, fsb, fcb}, e);
                end
            end
        end
        checks++;
        if (vs_low != 128) begin
            errors++;
            $display("FAIL vsync_low_time: %0d clks, required 128", vs_low);
        end
        checks++;
        if (fsb !== 1'b1 || fcb !== 4'd1) begin
            errors++;
            $display("FAIL restart_wrap: fs=%0b fc=%0d, required fs=1 fc=1", fsb, fcb);
        end
    endtask

    initial begin
        ra = 1'b0;
        rb = 1'b0;
        test_reset();
        test_pixel_tick();
        test_line();
        test_async_reset();
        test_bright();
        test_frame_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Produces the raster timing the rendering controller and sprite ROMs consume: hCount, vCount, bright, hSync, vSync for 640x480@60 Hz on the Nexys4 VGA port.
- Derives a 25 MHz pixel tick from the 100 MHz board clock.
- Provides frame_start and a 4-bit frame counter used as the gif/animation timebase.
- Sits between the top level and rendering_controller; its counters are the coordinates every ROM address offset is computed from.

Parameters:
- DIV, 4, board clocks per pixel (power of two, 2..8)
- H_SYNC, 96, hSync low width in pixels
- H_BP_END, 144, first visible hCount
- H_VIS_END, 784, first non-visible hCount after active video
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, vSync low width in lines
- V_BP_END, 35, first visible vCount
- V_VIS_END, 515, first non-visible vCount after active video
- V_TOTAL, 525, lines per frame

Ports:
- clk  input  1  100 MHz board clock
- reset  input  1  asynchronous, active-low reset
- hCount  output  10  horizontal pixel counter, 0..H_TOTAL-1
- vCount  output  10  vertical line counter, 0..V_TOTAL-1
- hSync  output  1  horizontal sync, active low
- vSync  output  1  vertical sync, active low
- bright  output  1  high inside the visible window
- pixel_tick  output  1  one-clk pulse, period DIV clocks
- frame_start  output  1  one-clk pulse on raster wrap to (0,0)
- frame_count  output  4  frames elapsed, mod 16

Behaviour:
- Reset is one clock domain, asynchronous assert and synchronous release. While reset=0 all outputs are held at these values:
  - hCount=0, vCount=0, divider=0
  - hSync=0, vSync=0 (position (0,0) lies inside both sync pulses)
  - bright=0, pixel_tick=0, frame_start=0, frame_count=0
- Divider: counts 0..DIV-1 every clk. pixel_tick=1 during the clk cycle where divider==DIV-1, else 0. First pulse occurs in the DIV-th cycle after reset release.
- Advance: on the clk edge that ends a pixel_tick=1 cycle:
  - hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - vCount wraps to 0 after V_TOTAL-1.
  - Counters never hold values >= their totals.
- Registered outputs, zero lag relative to the counters:
  - hSync = (hCount >= H_SYNC)
  - vSync = (vCount >= V_SYNC)
  - bright = (H_BP_END <= hCount < H_VIS_END) && (V_BP_END <= vCount < V_VIS_END)
  - These are computed from next-state counter values and registered, so they change on the same edge as the counters. No glitches are permitted.
- frame_start: high for exactly one clk, in the cycle after the edge where (799,524) wraps to (0,0). frame_count increments mod 16 on that same edge (15 -> 0).
- Timing totals:
  - One line = H_TOTAL*DIV = 3200 clks.
  - One frame = 800*525*4 = 1,680,000 clks.
  - Visible region per frame = 640*480 pixels.
- Reset mid-frame: outputs return immediately (asynchronously) to reset values. After release the raster restarts from (0,0); the partial frame does not pulse frame_start.
- frame_count is purely free-running. Consumers take modulus themselves; the block imposes no frame-length constraint.

Test Plan:
- Reset release, run 4 clks: pixel_tick high only in clk 4. hCount goes 0->1 on that edge. hSync=0, vSync=0, bright=0 throughout.
- Run one line (3200 clks from reset):
  - hSync rises exactly when hCount becomes 96.
  - vCount becomes 1 when hCount wraps 799->0.
  - Measured hSync low time = 384 clks.
- bright window:
  - At vCount=35, bright rises at hCount=144 and falls at hCount=784.
  - bright=0 on all of vCount 0..34 and 515..524.
  - Count bright clks per frame = 640*480*4 = 1,228,800.
- Frame wrap: after 1,680,000 clks, frame_start pulses one clk with hCount=0, vCount=0, frame_count=1. After 16 frames frame_count reads 0.
- Reset asserted at hCount=400, vCount=200:
  - All outputs go to reset values before the next clk edge.
  - After release, vSync low for 2 lines, and the first frame_start appears 1,680,000 clks later.
- Assertions on every clk:
  - hCount<800 and vCount<525.
  - bright implies hSync=1 and vSync=1.
  - pixel_tick period exactly 4.
